// File: rtl/usbfs_debug_uart_arbiter.sv
// usbfs_debug_uart_arbiter
// Shares one debug UART TX byte port among NREQ message sources. Arbitration
// is round-robin and message-atomic. Each granted message is framed on the
// wire as <tag> ':' <payload...> LF, where tag = TAG_BASE + requester index.
// A payload that stalls for TIMEOUT idle cycles is cut short with '~' LF.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   req_data   payload byte of requester i at bits [8i+7:8i]
//   req_valid  requester i presents a byte
//   req_last   requester i's byte is the last of its message
//   req_ready  requester i's byte is accepted this cycle (valid & ready)
//   tx_data    byte offered to the UART TX buffer
//   tx_en      tx_data is valid
//   tx_rdy     UART TX buffer accepts a byte (transfer = tx_en & tx_rdy)
//   grant      one-hot current owner, zero when idle
//   busy       arbiter is inside a message (not idle)
module usbfs_debug_uart_arbiter #(
  parameter int         NREQ     = 2,
  parameter int         TIMEOUT  = 65535,
  parameter logic [7:0] TAG_BASE = 8'h41
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_rdy,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  // The jump to TRUNC is taken on the idle cycle that brings the count to TIMEOUT.
  localparam logic [CW-1:0] TLIM = TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_TAG, S_SEP, S_DATA, S_TRUNC, S_EOL
  } state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx, rr_ptr, win, ptr_inc;
  logic [CW-1:0]   tcnt;
  logic [7:0]      req_bytes [NREQ];
  logic            any_valid, cur_valid, cur_last, data_xfer;

  // First valid requester found scanning ptr, ptr+1, ... modulo NREQ.
  function automatic logic [IDXW-1:0] pick_winner(input logic [NREQ-1:0] valid,
                                                  input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] w;
    logic            found;
    int              c;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      c = (int'(ptr) + i) % NREQ;
      if (!found && valid[IDXW'(c)]) begin
        found = 1'b1;
        w     = IDXW'(c);
      end
    end
    return w;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  assign any_valid = |req_valid;
  assign cur_valid = req_valid[idx];
  assign cur_last  = req_last[idx];
  assign data_xfer = cur_valid & tx_rdy;
  assign ptr_inc   = IDXW'((int'(idx) + 1) % NREQ);
  assign win       = pick_winner(req_valid, rr_ptr);
  assign busy      = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: emitting states only move on when the UART takes the byte.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_valid) state_nxt = S_TAG;
      S_TAG:   if (tx_rdy)    state_nxt = S_SEP;
      S_SEP:   if (tx_rdy)    state_nxt = S_DATA;
      S_DATA: begin
        if (data_xfer && cur_last)
          state_nxt = S_EOL;
        else if (TO_EN && !cur_valid && (tcnt == TLIM))
          state_nxt = S_TRUNC;
      end
      S_TRUNC: if (tx_rdy)    state_nxt = S_EOL;
      S_EOL:   if (tx_rdy)    state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Owner bookkeeping and the payload idle counter. The counter only runs
  // inside DATA, so it is already clear on every entry to DATA.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx    <= '0;
      rr_ptr <= '0;
      grant  <= '0;
      tcnt   <= '0;
    end else begin
      if (state == S_IDLE && any_valid) begin
        idx   <= win;
        grant <= NREQ'(1) << win;
      end
      if (state == S_EOL && tx_rdy) begin
        rr_ptr <= ptr_inc;
        grant  <= '0;
      end
      if (state == S_DATA && !cur_valid) begin
        if (tcnt != '1) tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

  // Output logic: DATA is a combinational pass-through of the owner's stream.
  always_comb begin
    tx_en     = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state)
      S_TAG: begin
        tx_en   = 1'b1;
        tx_data = TAG_BASE + 8'(idx);
      end
      S_SEP: begin
        tx_en   = 1'b1;
        tx_data = 8'h3A;
      end
      S_DATA: begin
        tx_en          = cur_valid;
        tx_data        = req_bytes[idx];
        req_ready[idx] = tx_rdy;
      end
      S_TRUNC: begin
        tx_en   = 1'b1;
        tx_data = 8'h7E;
      end
      S_EOL: begin
        tx_en   = 1'b1;
        tx_data = 8'h0A;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usbfs_debug_uart_arbiter.sv
// tb_usbfs_debug_uart_arbiter
// Drives two message sources and a throttled UART sink into the arbiter.
// Expected byte streams are built from message contents and the framing /
// round-robin rules; captured UART bytes are compared against them.
module tb_usbfs_debug_uart_arbiter;

  localparam int         NREQ     = 2;
  localparam int         TIMEOUT  = 8;
  localparam logic [7:0] TAG_BASE = 8'h41;

  logic              clk;
  logic              rstn;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_rdy;
  logic [NREQ-1:0]   grant;
  logic              busy;

  usbfs_debug_uart_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .TAG_BASE(TAG_BASE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_en(tx_en), .tx_rdy(tx_rdy),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic last; } sbyte_t;
  typedef struct { logic [NREQ-1:0] g; logic busy; logic xfer; logic [7:0] data; } cyc_t;

  sbyte_t     src      [NREQ][$];
  logic [7:0] exp_line [NREQ][$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  cyc_t       hist[$];
  int         gapcnt [NREQ];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         rdy_mode = 0;
  int         gap_pct  = 0;
  int         cyc      = 0;
  int         inv_err  = 0;

  // Index of the first difference between two byte queues, -1 when equal.
  function automatic int qdiff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    sbyte_t sb;
    sb.d = d;
    sb.last = last;
    src[r].push_back(sb);
  endtask

  // Queue a random message and append its framed line to the expectations.
  task automatic push_msg(input int r, input int len);
    logic [7:0] b;
    logic [7:0] tag;
    tag = TAG_BASE + 8'(r);
    exp_q.push_back(tag);   exp_line[r].push_back(tag);
    exp_q.push_back(8'h3A); exp_line[r].push_back(8'h3A);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(32, 125));
      push_byte(r, b, (i == len - 1));
      exp_q.push_back(b);
      exp_line[r].push_back(b);
    end
    exp_q.push_back(8'h0A); exp_line[r].push_back(8'h0A);
  endtask

  // One clock: drive at negedge, sample 1ns later (well before the posedge).
  task automatic step();
    cyc_t c;
    @(negedge clk);
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = (cyc % 3 == 0);
      default: tx_rdy = 1'($urandom_range(0, 1));
    endcase
    cyc++;
    for (int r = 0; r < NREQ; r++) begin
      if (src[r].size() > 0 && (gapcnt[r] >= 3 || $urandom_range(0, 99) >= gap_pct)) begin
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = src[r][0].d;
        req_last[r]        = src[r][0].last;
        gapcnt[r]          = 0;
      end else begin
        req_valid[r]       = 1'b0;
        req_data[8*r +: 8] = 8'($urandom);
        req_last[r]        = 1'($urandom);
        if (src[r].size() > 0) gapcnt[r]++;
      end
    end
    #1;
    c.g = grant; c.busy = busy; c.xfer = tx_en && tx_rdy; c.data = tx_data;
    hist.push_back(c);
    if (c.xfer) got.push_back(tx_data);
    for (int r = 0; r < NREQ; r++)
      if (req_valid[r] && req_ready[r]) src[r].delete(0);
    if ((req_ready & ~grant) != '0) inv_err++;
    if (req_ready != '0 && !tx_rdy) inv_err++;
    if (!$onehot0(grant)) inv_err++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      src[r].delete(); exp_line[r].delete(); gapcnt[r] = 0;
    end
    got.delete(); exp_q.delete(); hist.delete();
    cyc = 0; inv_err = 0; rdy_mode = 0; gap_pct = 0;
  endtask

  // Step until every queued byte is sent and the expected stream length is seen.
  task automatic drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((src[0].size() != 0 || src[1].size() != 0 || got.size() < exp_q.size()) && n < max_cyc) begin
      step();
      n++;
    end
    repeat (3) step();
    n_checks++;
    if (n >= max_cyc) $display("[TB] FAIL %s_drain: still pending after %0d cycles, required completion", name, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    int bad;
    rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_rdy = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (tx_en !== 1'b0) $display("[TB] FAIL reset_tx_en: got %b required 0", tx_en); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h required 00", tx_data); else n_pass++;
    n_checks++; if (grant !== 2'b00) $display("[TB] FAIL reset_grant: got %b required 00", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("[TB] FAIL reset_req_ready: got %b required 00", req_ready); else n_pass++;
    do_reset();
    repeat (4) step();
    bad = 0;
    foreach (hist[i]) if (hist[i].g !== 2'b00 || hist[i].busy !== 1'b0 || hist[i].xfer !== 1'b0) bad++;
    n_checks++; if (bad != 0) $display("[TB] FAIL reset_quiet: %0d active cycles, required 0", bad); else n_pass++;
  endtask

  task automatic test_single_stream();
    int d, bad_g, bad_b;
    logic [NREQ-1:0] eg;
    do_reset();
    push_byte(0, 8'h31, 1'b0); push_byte(0, 8'h32, 1'b0); push_byte(0, 8'h33, 1'b1);
    exp_q = '{8'h41, 8'h3A, 8'h31, 8'h32, 8'h33, 8'h0A};
    repeat (8) step();
    d = qdiff(got, exp_q);
    n_checks++;
    if (d >= 0) $display("[TB] FAIL single_stream: got %0d bytes required %0d, first difference at byte %0d", got.size(), exp_q.size(), d);
    else n_pass++;
    bad_g = 0; bad_b = 0;
    for (int i = 0; i < 8; i++) begin
      eg = (i >= 1 && i <= 6) ? 2'b01 : 2'b00;
      if (hist[i].g !== eg) bad_g++;
      if (hist[i].busy !== (i >= 1 && i <= 6)) bad_b++;
    end
    n_checks++; if (bad_g != 0) $display("[TB] FAIL single_grant_timeline: %0d wrong cycles, required 0", bad_g); else n_pass++;
    n_checks++; if (bad_b != 0) $display("[TB] FAIL single_busy_timeline: %0d wrong cycles, required 0", bad_b); else n_pass++;
    n_checks++; if (inv_err != 0) $display("[TB] FAIL single_ready_rules: %0d violations, required 0", inv_err); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int d;
    logic [NREQ-1:0] first_g;
    do_reset();
    push_msg(0, $urandom_range(1, 4));
    push_msg(1, $urandom_range(1, 4));
    drain(200, "simul_ab");
    d = qdiff(got, exp_q);
    n_checks++;
    if (d >= 0) $display("[TB] FAIL simul_order_ab: got %0d bytes required %0d, first difference at byte %0d", got.size(), exp_q.size(), d);
    else n_pass++;
    // A lone req0 message leaves the pointer at req1.
    got.delete(); exp_q.delete();
    push_msg(0, 2);
    drain(100, "simul_solo");
    got.delete(); exp_q.delete(); hist.delete();
    push_msg(1, $urandom_range(1, 4));
    push_msg(0, $urandom_range(1, 4));
    drain(200, "simul_ba");
    d = qdiff(got, exp_q);
    n_checks++;
    if (d >= 0) $display("[TB] FAIL simul_order_ba: got %0d bytes required %0d, first difference at byte %0d", got.size(), exp_q.size(), d);
    else n_pass++;
    first_g = '0;
    foreach (hist[i]) if (first_g == '0 && hist[i].g != '0) first_g = hist[i].g;
    n_checks++; if (first_g !== 2'b10) $display("[TB] FAIL simul_first_grant: got %b required 10", first_g); else n_pass++;
  endtask

  task automatic test_rdy_throttle();
    int d;
    do_reset();
    rdy_mode = 1;
    push_msg(1, 4);
    drain(200, "throttle");
    d = qdiff(got, exp_q);
    n_checks++;
    if (d >= 0) $display("[TB] FAIL throttle_stream: got %0d bytes required %0d, first difference at byte %0d", got.size(), exp_q.size(), d);
    else n_pass++;
    n_checks++; if (inv_err != 0) $display("[TB] FAIL throttle_ready_rules: %0d violations, required 0", inv_err); else n_pass++;
  endtask

  task automatic test_timeout();
    int d, idle;
    int xi[$];
    logic [7:0] b0, b1;
    do_reset();
    b0 = 8'($urandom_range(32, 125));
    b1 = 8'($urandom_range(32, 125));
    push_byte(0, b0, 1'b0);
    push_byte(0, b1, 1'b0);
    exp_q = '{8'h41, 8'h3A, b0, b1, 8'h7E, 8'h0A};
    push_msg(1, 3);
    drain(300, "timeout");
    d = qdiff(got, exp_q);
    n_checks++;
    if (d >= 0) $display("[TB] FAIL timeout_stream: got %0d bytes required %0d, first difference at byte %0d", got.size(), exp_q.size(), d);
    else n_pass++;
    foreach (hist[i]) if (hist[i].xfer) xi.push_back(i);
    idle = (xi.size() >= 5) ? (xi[4] - xi[3] - 1) : -1;
    n_checks++; if (idle != TIMEOUT) $display("[TB] FAIL timeout_idle_cycles: got %0d required %0d", idle, TIMEOUT); else n_pass++;
  endtask

  task automatic test_single_byte();
    int d, k;
    logic [7:0] x;
    logic [1:0] bb;
    do_reset();
    rdy_mode = 2;
    x = 8'($urandom_range(32, 125));
    push_byte(0, x, 1'b1);
    exp_q = '{8'h41, 8'h3A, x, 8'h0A};
    drain(200, "single_byte");
    d = qdiff(got, exp_q);
    n_checks++;
    if (d >= 0) $display("[TB] FAIL single_byte_stream: got %0d bytes required %0d, first difference at byte %0d", got.size(), exp_q.size(), d);
    else n_pass++;
    k = -1;
    foreach (hist[i]) if (hist[i].xfer && hist[i].data == 8'h0A) k = i;
    bb = (k >= 0 && k + 1 < hist.size()) ? {hist[k].busy, hist[k+1].busy} : 2'bxx;
    n_checks++; if (bb !== 2'b10) $display("[TB] FAIL single_byte_busy_drop: got %b required 10", bb); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d;
    logic [NREQ-1:0] first_g;
    do_reset();
    push_msg(0, 3);
    step();
    step();
    @(negedge clk);
    tx_rdy = 1'b0;
    #1;
    n_checks++;
    if ({tx_en, tx_data} !== {1'b1, 8'h3A}) $display("[TB] FAIL midreset_in_sep: got en=%b data=%h required en=1 data=3a", tx_en, tx_data);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({tx_en, grant, busy} !== 4'b0000) $display("[TB] FAIL midreset_async: got en=%b grant=%b busy=%b required all 0", tx_en, grant, busy);
    else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("[TB] FAIL midreset_ready: got %b required 00", req_ready); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    got.delete(); hist.delete();
    drain(200, "midreset");
    d = qdiff(got, exp_q);
    n_checks++;
    if (d >= 0) $display("[TB] FAIL midreset_restart: got %0d bytes required %0d, first difference at byte %0d", got.size(), exp_q.size(), d);
    else n_pass++;
    first_g = '0;
    foreach (hist[i]) if (first_g == '0 && hist[i].g != '0) first_g = hist[i].g;
    n_checks++; if (first_g !== 2'b01) $display("[TB] FAIL midreset_regrant: got %b required 01", first_g); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] per [NREQ][$];
    int cur, bad, d;
    do_reset();
    rdy_mode = 2;
    gap_pct  = 30;
    for (int round = 0; round < 8; round++) begin
      for (int r = 0; r < NREQ; r++)
        if ($urandom_range(0, 2) != 0) push_msg(r, $urandom_range(1, 6));
      repeat ($urandom_range(0, 15)) step();
    end
    drain(3000, "random");
    // Lines are atomic, so the capture splits cleanly into per-source lines.
    cur = -1; bad = 0;
    foreach (got[i]) begin
      if (cur < 0) begin
        if (got[i] >= TAG_BASE && got[i] < TAG_BASE + 8'(NREQ)) cur = int'(got[i] - TAG_BASE);
        else bad++;
      end
      if (cur >= 0) begin
        per[cur].push_back(got[i]);
        if (got[i] == 8'h0A) cur = -1;
      end
    end
    n_checks++; if (bad != 0) $display("[TB] FAIL random_framing: %0d stray bytes, required 0", bad); else n_pass++;
    for (int r = 0; r < NREQ; r++) begin
      d = qdiff(per[r], exp_line[r]);
      n_checks++;
      if (d >= 0) $display("[TB] FAIL random_lines_req%0d: got %0d bytes required %0d, first difference at byte %0d", r, per[r].size(), exp_line[r].size(), d);
      else n_pass++;
    end
    n_checks++; if (inv_err != 0) $display("[TB] FAIL random_ready_rules: %0d violations, required 0", inv_err); else n_pass++;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_rdy = 1'b0;
    for (int r = 0; r < NREQ; r++) gapcnt[r] = 0;
    test_reset();
    test_single_stream();
    test_simultaneous();
    test_rdy_throttle();
    test_timeout();
    test_single_byte();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
